mul_div_unit: RTL

- Iterative 32-bit multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits in the execute stage.
- Its hi/lo outputs feed the writeback result mux2 that serves MFHI/MFLO.
- The hazard unit stalls on busy.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_step.sv | 34 +++
 rtl/mul_div_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes and FSM states match the decode stage and the hazard unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(MDU_WIDTH);

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the MDU datapath: shift-add for multiply,
// restoring compare-subtract-shift for divide. Purely combinational.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_i[0] ? operand_i : {WIDTH{1'b0}})};
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand_i};

        // A set top bit of diff means the trial subtraction went negative.
        if (is_div) begin
            if (diff[WIDTH]) begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MDU_DIV0_FLAG_EN adds a div0 flag and a fast divide-by-zero path.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
`ifdef MDU_DIV0_FLAG_EN
    output logic             div0,
`endif
    output logic             done
);

    localparam int CW = (WIDTH == MDU_WIDTH) ? CNT_W : cnt_width(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef MDU_DIV0_FLAG_EN
    logic               div0_q, div0_d;
    logic               div0_pend_q, div0_pend_d;
`endif

    logic               signed_in, div_in, sign_a_in, sign_b_in;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               signed_q, neg_res, neg_rem;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;
    logic [2*WIDTH-1:0] acc_step;

    assign signed_in = (op == OP_MULT) || (op == OP_DIV);
    assign div_in    = (op == OP_DIV) || (op == OP_DIVU);
    assign sign_a_in = signed_in & a[WIDTH-1];
    assign sign_b_in = signed_in & b[WIDTH-1];
    assign abs_a     = sign_a_in ? -a : a;
    assign abs_b     = sign_b_in ? -b : b;

    // Sign fix uses magnitudes computed at launch; the remainder follows the dividend.
    assign signed_q  = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign neg_res   = signed_q & (sign_a_q ^ sign_b_q);
    assign neg_rem   = signed_q & sign_a_q;
    assign product   = neg_res ? -acc_q : acc_q;
    assign quotient  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remainder = neg_rem ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (op_q[1]),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        count_d   = count_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
        div0_d      = 1'b0;
        div0_pend_d = div0_pend_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = sign_a_in;
                    sign_b_d = sign_b_in;
                    busy_d   = 1'b1;
`ifdef MDU_DIV0_FLAG_EN
                    if (div_in && (b == '0)) begin
                        acc_d       = {a, {WIDTH{1'b1}}};
                        div0_pend_d = 1'b1;
                        state_d     = ST_FIX;
                    end else
`endif
                    begin
                        count_d   = CW'(WIDTH - 1);
                        acc_d     = {{WIDTH{1'b0}}, (div_in ? abs_a : abs_b)};
                        operand_d = div_in ? abs_b : abs_a;
                        state_d   = ST_CALC;
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end

            ST_CALC: begin
                acc_d   = acc_step;
                count_d = count_q - 1'b1;
                if (count_q == '0) state_d = ST_FIX;
            end

            ST_FIX: begin
`ifdef MDU_DIV0_FLAG_EN
                if (div0_pend_q) begin
                    hi_d        = acc_q[2*WIDTH-1:WIDTH];
                    lo_d        = acc_q[WIDTH-1:0];
                    div0_d      = 1'b1;
                    div0_pend_d = 1'b0;
                end else
`endif
                if (op_q[1]) begin
                    hi_d = remainder;
                    lo_d = quotient;
                end else begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // A reset mid-operation discards the accumulator, so nothing partial reaches HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
            operand_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q      <= 1'b0;
            div0_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            operand_q   <= operand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MDU_DIV0_FLAG_EN
            div0_q      <= div0_d;
            div0_pend_q <= div0_pend_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef MDU_DIV0_FLAG_EN
    assign div0 = div0_q;
`endif

endmodule
